// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage with IF/ID pipeline register
//
// Purpose: holds the PC and drives a single-port instruction-memory handshake.
// It selects the next PC from the ID redirect and presents the fetched
// instruction with its PC+4 to decode. It supports hazard stalls, and it
// squashes the wrong-path fetch on every taken redirect.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   stall        hold PC and IF/ID; a word returned during stall is parked
//   pc_src       00 sequential, 01 branch, 10 jump, 11 jump-register
//   branch       branch target
//   offset28     jump offset (already shifted left by 2)
//   jr_target    forwarded rs value for jump-register
//   imem_req     fetch request (asserted in FETCH only)
//   imem_addr    fetch address, always the current PC
//   imem_ready   imem_rdata is valid for imem_addr this cycle
//   imem_rdata   fetched instruction word
//   ins          IF/ID instruction
//   pc_4_out     IF/ID PC+4 of ins
//   valid        IF/ID holds a real instruction rather than a bubble
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [27:0] offset28,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] pc_4_out,
  output logic        valid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [31:0] r_pc_4;
  logic        r_valid;
  logic [31:0] r_hold_ins;

  logic [31:0] w_tgt_raw;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_plus4;
  logic        w_redirect;

  // A jump takes its upper PC bits from the jump's own PC+4, which is
  // still sitting in IF/ID while ID resolves it.
  always_comb begin
    w_tgt_raw = branch;
    case (pc_src)
      2'b01:   w_tgt_raw = branch;
      2'b10:   w_tgt_raw = {r_pc_4[31:28], offset28};
      2'b11:   w_tgt_raw = jr_target;
      default: w_tgt_raw = branch;
    endcase
  end

  assign w_tgt      = w_tgt_raw & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = (pc_src != 2'b00);

  // The request depends only on registered state, so imem_ready never
  // reaches imem_addr combinationally.
  assign imem_req  = (r_state == FETCH);
  assign imem_addr = r_pc;
  assign ins       = r_ins;
  assign pc_4_out  = r_pc_4;
  assign valid     = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_ins      <= NOP;
      r_pc_4     <= 32'd0;
      r_valid    <= 1'b0;
      r_hold_ins <= NOP;
    end else begin
      case (r_state)
        FETCH: begin
          if (stall) begin
            // Park a word that arrives during a stall so that the release
            // does not have to fetch it again.
            if (imem_ready) begin
              r_hold_ins <= imem_rdata;
              r_state    <= HOLD;
            end
          end else if (w_redirect) begin
            r_pc    <= w_tgt;
            r_ins   <= NOP;
            r_pc_4  <= 32'd0;
            r_valid <= 1'b0;
          end else if (imem_ready) begin
            r_ins   <= imem_rdata;
            r_pc_4  <= w_pc_plus4;
            r_valid <= 1'b1;
            r_pc    <= w_pc_plus4;
          end else begin
            r_ins   <= NOP;
            r_pc_4  <= 32'd0;
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (stall) begin
            r_state <= HOLD;
          end else if (w_redirect) begin
            r_pc    <= w_tgt;
            r_ins   <= NOP;
            r_pc_4  <= 32'd0;
            r_valid <= 1'b0;
            r_state <= FETCH;
          end else begin
            r_ins   <= r_hold_ins;
            r_pc_4  <= w_pc_plus4;
            r_valid <= 1'b1;
            r_pc    <= w_pc_plus4;
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
